// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage load/store engine. Issues one Wishbone classic-pipelined
// transaction per RV32I load/store, stalls the pipeline until the access completes, and
// returns lane-aligned, sign/zero-extended load data.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned half/word accesses instead
// of performing them with the offending low address bits ignored.
module load_store_unit #(
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    input  logic                  req_wr,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  stall,
    output logic                  done,
    output logic [31:0]           load_data,
    output logic                  bus_err,
    output logic                  misalign,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_wr_en,
    output logic [ADDR_WIDTH-1:0] wb_addr,
    output logic [31:0]           wb_wr_data,
    output logic [3:0]            wb_sel,
    input  logic                  wb_ack,
    input  logic                  wb_stall,
    input  logic [31:0]           wb_rd_data
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    state_e state_q, state_d;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      off_q, off_d;

    logic                  cyc_d, stb_d, wr_en_d, done_d, bus_err_d, misalign_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [31:0]           wr_data_d, load_data_d;
    logic [3:0]            sel_d;

    logic        accept, req_legal, req_misaligned, finish_ok, timeout_hit, abort;
    logic [3:0]  req_sel;
    logic [31:0] req_lane_data, extracted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_WIDTH];

    assign accept = (state_q == StIdle) && req_valid && !done;
    assign stall  = (state_q != StIdle) || (req_valid && !done);

    // Decode legality, misalignment and byte lanes of the presented request.
    always_comb begin
        req_legal     = 1'b0;
        req_sel       = 4'b1111;
        req_lane_data = req_wdata;
        if (req_wr) begin
            req_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                        (req_funct3 == 3'b010);
            unique case (req_funct3[1:0])
                2'b00: begin
                    req_sel       = 4'b0001 << req_addr[1:0];
                    req_lane_data = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    req_sel       = req_addr[1] ? 4'b1100 : 4'b0011;
                    req_lane_data = {2{req_wdata[15:0]}};
                end
                default: begin
                    req_sel       = 4'b1111;
                    req_lane_data = req_wdata;
                end
            endcase
        end else begin
            req_legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) &&
                        (req_funct3 != 3'b111);
        end
    end

`ifdef MISALIGN_TRAP_EN
    assign req_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                            ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign req_misaligned = 1'b0;
`endif

    // Completion and abort conditions for an outstanding bus cycle; ack wins over timeout.
    always_comb begin
        finish_ok   = ((state_q == StReq) && !wb_stall && wb_ack) ||
                      ((state_q == StWait) && wb_ack);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
        abort       = (state_q != StIdle) && !finish_ok && timeout_hit;
    end

    // Extract and extend load data from the latched lane offset and funct3.
    always_comb begin
        byte_v    = 8'(wb_rd_data >> {off_q, 3'b000});
        half_v    = off_q[1] ? wb_rd_data[31:16] : wb_rd_data[15:0];
        extracted = wb_rd_data;
        unique case (funct3_q[1:0])
            2'b00:   extracted = {{24{byte_v[7] & ~funct3_q[2]}}, byte_v};
            2'b01:   extracted = {{16{half_v[15] & ~funct3_q[2]}}, half_v};
            default: extracted = wb_rd_data;
        endcase
        if (wr_q) begin
            extracted = 32'h0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && req_legal && !req_misaligned) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (finish_ok || abort) begin
                    state_d = StIdle;
                end else if (!wb_stall) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (finish_ok || abort) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs, latched request and timeout counter.
    always_comb begin
        cyc_d       = wb_cyc;
        stb_d       = wb_stb;
        wr_en_d     = wb_wr_en;
        addr_d      = wb_addr;
        wr_data_d   = wb_wr_data;
        sel_d       = wb_sel;
        done_d      = 1'b0;
        load_data_d = load_data;
        bus_err_d   = bus_err;
        misalign_d  = misalign;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    cnt_d    = '0;
                    wr_d     = req_wr;
                    funct3_d = req_funct3;
                    off_d    = req_addr[1:0];
                    if (!req_legal) begin
                        done_d      = 1'b1;
                        bus_err_d   = 1'b1;
                        misalign_d  = 1'b0;
                        load_data_d = 32'h0;
                    end else if (req_misaligned) begin
                        done_d      = 1'b1;
                        bus_err_d   = 1'b0;
                        misalign_d  = 1'b1;
                        load_data_d = 32'h0;
                    end else begin
                        cyc_d     = 1'b1;
                        stb_d     = 1'b1;
                        wr_en_d   = req_wr;
                        addr_d    = {req_addr[ADDR_WIDTH-1:2], 2'b00};
                        sel_d     = req_wr ? req_sel : 4'b1111;
                        wr_data_d = req_wr ? req_lane_data : 32'h0;
                    end
                end
            end
            StReq, StWait: begin
                cnt_d = cnt_q + 1'b1;
                if (finish_ok || abort) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    wr_en_d     = 1'b0;
                    done_d      = 1'b1;
                    misalign_d  = 1'b0;
                    bus_err_d   = abort;
                    load_data_d = abort ? 32'h0 : extracted;
                end else if ((state_q == StReq) && !wb_stall) begin
                    // Strobe accepted; hold cyc while waiting for the ack.
                    stb_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            wb_wr_en   <= 1'b0;
            wb_addr    <= '0;
            wb_wr_data <= 32'h0;
            wb_sel     <= 4'b0000;
            done       <= 1'b0;
            load_data  <= 32'h0;
            bus_err    <= 1'b0;
            misalign   <= 1'b0;
            cnt_q      <= '0;
            wr_q       <= 1'b0;
            funct3_q   <= 3'b000;
            off_q      <= 2'b00;
        end else begin
            wb_cyc     <= cyc_d;
            wb_stb     <= stb_d;
            wb_wr_en   <= wr_en_d;
            wb_addr    <= addr_d;
            wb_wr_data <= wr_data_d;
            wb_sel     <= sel_d;
            done       <= done_d;
            load_data  <= load_data_d;
            bus_err    <= bus_err_d;
            misalign   <= misalign_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            funct3_q   <= funct3_d;
            off_q      <= off_d;
        end
    end

endmodule
